// File: rtl/fifo_sink_sim.sv
// fifo_sink_sim
// Simulation-side consumer that drains the sample FIFO written by the source
// model. It issues registered read strobes on a wrapping address while the
// FIFO is not almost-empty, captures the returned word RD_LATENCY cycles
// later, and checks it against the ramp 0, 1, 2, ...
//
// Ports
//   clk        : clock, all logic on the rising edge
//   rst        : synchronous active-high reset
//   en         : run enable; low pauses new reads
//   Aempty     : FIFO almost-empty; high blocks new reads
//   rdata      : FIFO read data
//   RE         : registered read strobe
//   addr       : read address, valid while RE is high
//   dout       : last captured word
//   dout_valid : one-cycle pulse per captured word
//   err_cnt    : saturating count of ramp mismatches
//   done       : sticky end-of-run flag, cleared only by rst
module fifo_sink_sim #(
  parameter int ADDR_WIDTH  = $clog2(100),
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_SAMPLES = 100,
  parameter int RD_LATENCY  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  Aempty,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  RE,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic [15:0]           err_cnt,
  output logic                  done
);

  // Sized so that the counters can hold NUM_SAMPLES itself and never wrap.
  localparam int CW = $clog2(NUM_SAMPLES + 1);
  localparam logic [CW-1:0] N_C = CW'(NUM_SAMPLES);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_e;

  state_e                state_q, state_d;
  logic                  re_q, re_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CW-1:0]         issued_q, issued_d;
  logic [CW-1:0]         rcv_q, rcv_d;
  logic [RD_LATENCY-1:0] sr_q, sr_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  dv_q, dv_d;
  logic [15:0]           err_q, err_d;
  logic                  tap;
  logic [DATA_WIDTH-1:0] exp_w;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // A read strobed RD_LATENCY cycles ago has its data on rdata now.
  assign tap   = sr_q[RD_LATENCY-1];
  assign exp_w = DATA_WIDTH'(rcv_q);

  always_comb begin
    state_d  = state_q;
    re_d     = 1'b0;
    addr_d   = re_q ? addr_q + 1'b1 : addr_q;
    issued_d = issued_q;
    rcv_d    = rcv_q;
    dout_d   = dout_q;
    dv_d     = tap;
    err_d    = err_q;

    sr_d[0] = re_q;
    for (int i = 1; i < RD_LATENCY; i++) begin
      sr_d[i] = sr_q[i-1];
    end

    // Capture and ramp check
    if (tap) begin
      dout_d = rdata;
      if (rdata != exp_w) begin
        err_d = sat_inc(err_q);
      end
      rcv_d = rcv_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (en) begin
          state_d = READ;
        end
      end
      READ: begin
        if (issued_q == N_C) begin
          state_d = DRAIN;
        end else begin
          re_d = en & ~Aempty;
          if (re_d) begin
            issued_d = issued_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (sr_q == '0 && rcv_q == N_C) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Register stage: strobe, address, in-flight tracker and capture registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      re_q     <= 1'b0;
      addr_q   <= '0;
      issued_q <= '0;
      rcv_q    <= '0;
      sr_q     <= '0;
      dout_q   <= '0;
      dv_q     <= 1'b0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      re_q     <= re_d;
      addr_q   <= addr_d;
      issued_q <= issued_d;
      rcv_q    <= rcv_d;
      sr_q     <= sr_d;
      dout_q   <= dout_d;
      dv_q     <= dv_d;
      err_q    <= err_d;
    end
  end

  assign RE         = re_q;
  assign addr       = addr_q;
  assign dout       = dout_q;
  assign dout_valid = dv_q;
  assign err_cnt    = err_q;
  assign done       = (state_q == DONE);

endmodule

// File: tb/tb_fifo_sink_sim.sv
// Bench for fifo_sink_sim: two instances (default configuration and a small
// wrapping one with longer read latency) each driven by a FIFO model and
// checked every cycle against a transaction-level reference model.
module tb_fifo_sink_sim;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst_v, en_v, ae_v;
  logic [15:0] rdata0, rdata1;
  logic        re0, re1, dv0, dv1, done0, done1;
  logic [6:0]  addr0;
  logic [2:0]  addr1;
  logic [15:0] dout0, dout1, err0, err1;

  fifo_sink_sim dut0 (
    .clk(clk), .rst(rst_v[0]), .en(en_v[0]), .Aempty(ae_v[0]), .rdata(rdata0),
    .RE(re0), .addr(addr0), .dout(dout0), .dout_valid(dv0), .err_cnt(err0),
    .done(done0)
  );

  fifo_sink_sim #(.ADDR_WIDTH(3), .NUM_SAMPLES(20), .RD_LATENCY(3)) dut1 (
    .clk(clk), .rst(rst_v[1]), .en(en_v[1]), .Aempty(ae_v[1]), .rdata(rdata1),
    .RE(re1), .addr(addr1), .dout(dout1), .dout_valid(dv1), .err_cnt(err1),
    .done(done1)
  );

  typedef struct {int cyc; int idx;} ev_t;
  ev_t q0[$];
  ev_t q1[$];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  bit          armed[2];
  int          issued[2], captured[2], exp_err[2], exp_addr[2];
  int          corrupt[2], env_idx[2];
  bit          exp_re[2], exp_dv[2], exp_done[2];
  logic [15:0] exp_dout[2];
  int          hist[2][4];

  function automatic int nsam(int i);
    return (i == 0) ? 100 : 20;
  endfunction

  function automatic int lat(int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic int amask(int i);
    return (i == 0) ? 127 : 7;
  endfunction

  // Word the FIFO model returns for its idx-th read.
  function automatic logic [15:0] word(int i, int idx);
    return (idx == corrupt[i]) ? 16'h00FF : 16'(idx);
  endfunction

  task automatic chk(string nm, int i, logic [31:0] act, logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s inst%0d cycle %0d: got 0x%0h, expected 0x%0h",
               nm, i, cyc, act, expv);
    end
  endtask

  task automatic model_step(int i, bit s_rst, bit s_en, bit s_ae);
    ev_t e;
    bit  nre;
    e.cyc = 0;
    e.idx = 0;
    if (s_rst) begin
      armed[i] = 0; issued[i] = 0; captured[i] = 0; exp_err[i] = 0;
      exp_dout[i] = '0; exp_dv[i] = 0; exp_re[i] = 0; exp_done[i] = 0;
      env_idx[i] = 0;
      if (i == 0) q0.delete(); else q1.delete();
      return;
    end
    // done follows the pulse carrying the final sample by one cycle
    exp_done[i] = exp_done[i] | (exp_dv[i] && captured[i] == nsam(i));
    nre = armed[i] && s_en && !s_ae && issued[i] < nsam(i);
    armed[i] = armed[i] | s_en;
    exp_re[i] = nre;
    if (nre) begin
      exp_addr[i] = issued[i] & amask(i);
      e.cyc = cyc + lat(i) + 1;
      e.idx = issued[i];
      if (i == 0) q0.push_back(e); else q1.push_back(e);
      issued[i]++;
    end
    exp_dv[i] = 0;
    if (i == 0 && q0.size() > 0 && q0[0].cyc == cyc) begin
      e = q0.pop_front();
      exp_dv[i] = 1;
    end else if (i == 1 && q1.size() > 0 && q1[0].cyc == cyc) begin
      e = q1.pop_front();
      exp_dv[i] = 1;
    end
    if (exp_dv[i]) begin
      exp_dout[i] = word(i, e.idx);
      if (exp_dout[i] != 16'(captured[i]) && exp_err[i] != 65535) exp_err[i]++;
      captured[i]++;
    end
  endtask

  task automatic compare(int i);
    logic        re, dv, dn;
    logic [15:0] ad, dt, er;
    if (i == 0) begin
      re = re0; dv = dv0; dn = done0; ad = 16'(addr0); dt = dout0; er = err0;
    end else begin
      re = re1; dv = dv1; dn = done1; ad = 16'(addr1); dt = dout1; er = err1;
    end
    chk("RE", i, 32'(re), 32'(exp_re[i]));
    if (exp_re[i]) chk("addr", i, 32'(ad), 32'(exp_addr[i]));
    chk("dout_valid", i, 32'(dv), 32'(exp_dv[i]));
    chk("dout", i, 32'(dt), 32'(exp_dout[i]));
    chk("err_cnt", i, 32'(er), 32'(exp_err[i]));
    chk("done", i, 32'(dn), 32'(exp_done[i]));
  endtask

  // FIFO model: returns its read data RD_LATENCY cycles after each strobe.
  task automatic env_step(int i);
    logic        re;
    logic [15:0] val;
    int          h;
    re = (i == 0) ? re0 : re1;
    for (int k = 3; k >= 1; k--) hist[i][k] = hist[i][k-1];
    if (re === 1'b1) begin
      hist[i][0] = env_idx[i];
      env_idx[i]++;
    end else begin
      hist[i][0] = -1;
    end
    h = hist[i][lat(i)];
    val = (h >= 0) ? word(i, h) : 16'hDEAD;
    if (i == 0) rdata0 = val; else rdata1 = val;
  endtask

  task automatic cycle();
    logic [1:0] r, e, a;
    @(posedge clk);
    r = rst_v; e = en_v; a = ae_v;
    #1;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      model_step(i, r[i], e[i], a[i]);
      compare(i);
      env_step(i);
    end
  endtask

  typedef struct {
    int          inst;
    bit          bp;
    int          pause_at;
    int          corr;
    int          rst_at;
    int          exp_err;
    logic [15:0] exp_dout;
    int          exp_caps;
  } vec_t;

  task automatic run_scn(vec_t v);
    int i, t, pause_left, dv_cnt, first_re, first_dv;
    bit rst_used, pause_used, inj_seen;
    logic dn, re, dv;
    logic [15:0] er, dt;
    i = v.inst; t = 0; pause_left = 0; dv_cnt = 0; first_re = -1; first_dv = -1;
    rst_used = 0; pause_used = 0; inj_seen = 0;
    corrupt[i] = v.corr;
    rst_v[i] = 1'b1; en_v[i] = 1'b0; ae_v[i] = 1'b0;
    cycle();
    rst_v[i] = 1'b0;
    dn = (i == 0) ? done0 : done1;
    er = (i == 0) ? err0 : err1;
    chk("reset_done", i, 32'(dn), 32'd0);
    chk("reset_err", i, 32'(er), 32'd0);
    en_v[i] = 1'b1;
    while (dn !== 1'b1 && t < 3000) begin
      ae_v[i] = v.bp ? ((t % 10) >= 5) : 1'b0;
      if (v.pause_at >= 0 && !pause_used && issued[i] >= v.pause_at) begin
        pause_left = 8;
        pause_used = 1;
      end
      if (pause_left > 0) begin
        en_v[i] = 1'b0;
        pause_left--;
      end else begin
        en_v[i] = 1'b1;
      end
      rst_v[i] = 1'b0;
      if (v.rst_at >= 0 && !rst_used && issued[i] >= v.rst_at) begin
        rst_v[i] = 1'b1;
        rst_used = 1;
        dv_cnt = 0;
      end
      cycle();
      t++;
      rst_v[i] = 1'b0;
      re = (i == 0) ? re0 : re1;
      dv = (i == 0) ? dv0 : dv1;
      dn = (i == 0) ? done0 : done1;
      if (dv === 1'b1) dv_cnt++;
      if (first_re < 0 && re === 1'b1) first_re = cyc;
      if (first_dv < 0 && dv === 1'b1) first_dv = cyc;
      if (v.corr >= 0 && !inj_seen && captured[i] == v.corr + 1) begin
        inj_seen = 1;
        chk("inject_err_cnt", i, 32'((i == 0) ? err0 : err1), 32'd1);
        chk("inject_dout", i, 32'((i == 0) ? dout0 : dout1), 32'h00FF);
      end
    end
    chk("done_within_budget", i, 32'(dn), 32'd1);
    ae_v[i] = 1'b0;
    // en toggling after completion must not start new reads
    repeat (5) begin
      en_v[i] = ~en_v[i];
      cycle();
      dv = (i == 0) ? dv0 : dv1;
      if (dv === 1'b1) dv_cnt++;
    end
    en_v[i] = 1'b0;
    er = (i == 0) ? err0 : err1;
    dt = (i == 0) ? dout0 : dout1;
    dn = (i == 0) ? done0 : done1;
    chk("final_err_cnt", i, 32'(er), 32'(v.exp_err));
    chk("final_dout", i, 32'(dt), 32'(v.exp_dout));
    chk("final_done", i, 32'(dn), 32'd1);
    chk("capture_count", i, 32'(dv_cnt), 32'(v.exp_caps));
    if (i == 1) chk("re_to_dout_valid", i, 32'(first_dv - first_re), 32'd4);
  endtask

  vec_t tbl[6];

  initial begin
    //            inst bp    pause corr rst  err dout    caps
    tbl[0] = '{0, 1'b0, -1, -1, -1, 0, 16'd99, 100};  // free run
    tbl[1] = '{0, 1'b1, -1, -1, -1, 0, 16'd99, 100};  // backpressure
    tbl[2] = '{0, 1'b0, -1,  6, -1, 1, 16'd99, 100};  // error injection
    tbl[3] = '{1, 1'b0, -1, -1, -1, 0, 16'd19, 20};   // wrap and latency
    tbl[4] = '{0, 1'b0, 30, -1, -1, 0, 16'd99, 100};  // pause
    tbl[5] = '{0, 1'b0, -1, -1, 50, 0, 16'd99, 100};  // reset mid-run

    rst_v = 2'b11; en_v = 2'b00; ae_v = 2'b00;
    rdata0 = 16'hDEAD; rdata1 = 16'hDEAD;
    for (int i = 0; i < 2; i++) begin
      corrupt[i] = -1;
      for (int k = 0; k < 4; k++) hist[i][k] = -1;
    end
    cycle();
    cycle();
    rst_v = 2'b00;
    chk("reset_RE", 0, 32'(re0), 32'd0);
    chk("reset_addr", 0, 32'(addr0), 32'd0);
    chk("reset_dout", 0, 32'(dout0), 32'd0);
    chk("reset_dout_valid", 1, 32'(dv1), 32'd0);

    for (int s = 0; s < 6; s++) begin
      run_scn(tbl[s]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_sink_sim.md
# fifo_sink_sim

Simulation-side consumer that drains the sample FIFO filled by the source model. Issues registered read strobes with a wrapping read address whenever the FIFO is not almost-empty, captures returned data after a fixed read latency, and checks each word against the expected ramp (0, 1, 2, …). Lives in `hdl/sim/lib` and terminates the write/read path in the IntPol2 benches, reporting mismatches and an end-of-run flag.

## Interface
- `ADDR_WIDTH`, default `$clog2(100)` (7): FIFO read-address width.
- `DATA_WIDTH`, default 16: FIFO data width.
- `NUM_SAMPLES`, default 100: total reads to issue before completion; must be ≥1.
- `RD_LATENCY`, default 1: cycles from the `RE` cycle to the `rdata` valid cycle; must be ≥1.

- `clk` in 1: clock. One clock; all logic on rising edge.
- `rst` in 1: reset. Synchronous, active-high.
- `en` in 1: run enable; low pauses new reads.
- `Aempty` in 1: FIFO almost-empty; high blocks new reads.
- `rdata` in DATA_WIDTH: FIFO read data.
- `RE` out 1: read strobe (registered).
- `addr` out ADDR_WIDTH: read address; valid while `RE`=1.
- `dout` out DATA_WIDTH: last captured word.
- `dout_valid` out 1: one-cycle pulse per captured word.
- `err_cnt` out 16: saturating mismatch count.
- `done` out 1: sticky completion flag.

## Operation
- States: IDLE, READ, DRAIN, DONE.
- IDLE: `RE`=0. `en`=1 → READ on next edge.
- READ, each edge: `RE` <= `en` & ~`Aempty` & (issued < NUM_SAMPLES); issued increments when it goes 1. If `RE` was 1 in the ending cycle, `addr` <= `addr`+1, wrapping 2^ADDR_WIDTH−1 → 0. Back-to-back reads allowed: one read per cycle at full rate.
- When issued reaches NUM_SAMPLES, state → DRAIN; `RE` stays 0.
- `en` low in READ: no new reads issued; state stays READ; in-flight reads still captured.
- In-flight tracking: RD_LATENCY-deep shift register of `RE`. Exiting tap high → capture `rdata` into `dout`, pulse `dout_valid`.
- Checker: expected = rcv_cnt[DATA_WIDTH-1:0], rcv_cnt starting at 0. Each capture: if `rdata` ≠ expected, `err_cnt`+1, saturating at 16'hFFFF. Then rcv_cnt+1.
- DRAIN → DONE when the shift register is all-zero and rcv_cnt = NUM_SAMPLES. DONE asserts `done`=1 and holds it until `rst`; no further reads are issued; `en` is ignored.
- issued and rcv_cnt are $clog2(NUM_SAMPLES+1) bits wide and never wrap.

## Timing
- Reset values: `RE`=0, `addr`=0, `dout`=0, `dout_valid`=0, `err_cnt`=0, `done`=0. State = IDLE, counters and shift register cleared.
- `rst` high at an edge overrides everything, including mid-READ and mid-DRAIN. In-flight data returned afterwards is ignored.
- Condition sampled at edge k → `RE` high in cycle k..k+1. `rdata` is sampled at the edge RD_LATENCY cycles after the `RE` cycle, and `dout`/`dout_valid` appear in the following cycle. Total `RE`-to-`dout_valid` latency = RD_LATENCY+1 cycles.
- `Aempty` rising: a read already registered in the current cycle completes; the blocking takes effect from the next edge.
- `done` rises one cycle after the last `dout_valid` pulse.
- `en` to first `RE`: 2 edges (IDLE→READ, then the `RE` register).

## Test plan
- Free run: `en`=1, `Aempty`=0, FIFO model returns the ramp with RD_LATENCY=1 → 100 contiguous `RE` cycles with `addr` 0..99, 100 `dout_valid` pulses with `dout` 0..99, `err_cnt`=0, `done`=1 one cycle after the last pulse.
- Backpressure: toggle `Aempty` high for 5 cycles every 10 → `RE` low exactly while blocked (one cycle of lag). No address skipped or repeated. Final `err_cnt`=0.
- Error injection: corrupt the 7th returned word (expected 6, drive 0x00FF) → `err_cnt`=1 after that capture. `dout` shows 0x00FF. Run still ends with `done`=1.
- Wrap and latency: ADDR_WIDTH=3, NUM_SAMPLES=20, RD_LATENCY=3 → `addr` sequence 0..7,0..7,0..3. `RE`-to-`dout_valid` = 4 cycles. `done`=1 with `err_cnt`=0.
- Pause: drop `en` for 8 cycles after 30 reads → no `RE` while `en` is low. The remaining in-flight words are still checked. Resuming continues from `addr`=30.
- Reset mid-run: assert `rst` after 50 reads for 1 cycle → all outputs zero at the next edge. The following run restarts at `addr`=0 and expects 0 first, with no false errors.
